// File: rtl/casex_code_gen.sv
// Burst code generator: accepts a class/length request and emits req_len+1
// class codes over a valid/ready handshake, then idles for GAP cycles.
//
// state  | meaning
// IDLE   | ready for a request; c shows 3'b111
// EMIT   | c_valid high, presenting the code of the latched class
// GAP_S  | post-burst idle, GAP cycles, no request accepted
module casex_code_gen #(
  parameter int GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic [3:0] req_len,
  output logic [2:0] c,
  output logic       c_valid,
  input  logic       c_ready,
  output logic       err,
  output logic       busy,
  output logic [7:0] cnt_st1,
  output logic [7:0] cnt_st2,
  output logic [7:0] cnt_st3
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EMIT  = 2'd1;
  localparam logic [1:0] GAP_S = 2'd2;

  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  logic [1:0] state;
  logic [1:0] sel_q;
  logic [3:0] remaining;
  logic [3:0] gap_cnt;
  logic       t;
  logic       err_q;
  logic       accept;
  logic       xfer;
  logic [2:0] code;

  assign req_ready = (state == IDLE);
  assign c_valid   = (state == EMIT);
  assign busy      = (state != IDLE);
  assign err       = err_q;
  assign accept    = req_valid & req_ready;
  assign xfer      = c_valid & c_ready;

  always_comb begin
    code = 3'b111;
    case (sel_q)
      2'b01:   code = {2'b00, t};
      2'b10:   code = 3'b100;
      2'b11:   code = 3'b001;
      default: code = 3'b111;
    endcase
  end

  // Idle code 3'b111 never collides with any class pattern.
  assign c = c_valid ? code : 3'b111;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_q     <= 2'b00;
      remaining <= 4'd0;
      gap_cnt   <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_sel == 2'b00) begin
              err_q <= 1'b1;
            end else begin
              sel_q     <= req_sel;
              remaining <= req_len;
              state     <= EMIT;
            end
          end
        end
        EMIT: begin
          if (xfer) begin
            if (remaining != 4'd0) begin
              remaining <= remaining - 4'd1;
            end else if (GAP > 0) begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP_S;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP_S: begin
          if (gap_cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t       <= 1'b0;
      cnt_st1 <= 8'd0;
      cnt_st2 <= 8'd0;
      cnt_st3 <= 8'd0;
    end else if (xfer) begin
      case (sel_q)
        2'b01: begin
          t <= ~t;
          if (cnt_st1 != 8'hFF) cnt_st1 <= cnt_st1 + 8'd1;
        end
        2'b10: if (cnt_st2 != 8'hFF) cnt_st2 <= cnt_st2 + 8'd1;
        2'b11: if (cnt_st3 != 8'hFF) cnt_st3 <= cnt_st3 + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/casex_code_gen.md
CASEX_CODE_GEN -- requirements
Module: casex_code_gen

Interface
REQ-001 SHALL provide parameter: GAP, default 1, number of idle cycles inserted after each burst (legal 0..15).
REQ-002 SHALL provide ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_sel  in  2  class: 01=st1, 10=st2, 11=st3, 00=illegal.
- req_len  in  4  burst length minus one (emits req_len+1 codes, 1..16).
- c  out  3  generated code.
- c_valid  out  1  c carries a code.
- c_ready  in  1  downstream accepts c.
- err  out  1  one-cycle pulse on illegal request.
- busy  out  1  high in EMIT or GAP.
- cnt_st1, cnt_st2, cnt_st3  out  8 each  saturating count of transferred codes per class.

Function
REQ-003 SHALL implement FSM states IDLE, EMIT, GAP.
REQ-004 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-005 On an accepted request with req_sel=00, SHALL stay in IDLE, emit no code, and assert err for exactly the next cycle.
REQ-006 On an accepted legal request, SHALL latch req_sel, load remaining=req_len, and enter EMIT so that c_valid=1 in the following cycle (1-cycle latency).
REQ-007 Codes in EMIT SHALL be as follows:
- st1 = {2'b00, t}, where t is a toggle register (reset 0) that inverts after every st1 transfer.
- st2 = 3'b100.
- st3 = 3'b001.
REQ-008 A transfer SHALL occur on each edge with c_valid=1 and c_ready=1; c and c_valid SHALL hold stable while c_ready=0.
REQ-009 On a transfer in EMIT:
- remaining>0: decrement remaining and stay in EMIT.
- remaining=0: go to GAP if GAP>0, else to IDLE.
REQ-010 In GAP, SHALL hold c_valid=0 and req_ready=0 for exactly GAP cycles, then enter IDLE.
REQ-011 When c_valid=0, c SHALL be 3'b111 (matches no class pattern).
REQ-012 The matching cnt_stN SHALL increment by 1 per transfer and saturate at 8'hFF; no counter SHALL change without a transfer.
REQ-013 busy SHALL be 1 in EMIT and GAP and 0 in IDLE.
REQ-014 req_sel and req_len changes outside acceptance SHALL have no effect on an ongoing burst.
REQ-015 For back-to-back requests with GAP=0, the next request SHALL be accepted in the IDLE cycle following the last transfer; no code SHALL be emitted in that cycle.

Reset
REQ-016 While rst_n=0 at a rising edge, the block SHALL reset on that edge, with the following values:
- state=IDLE, t=0, remaining=0.
- req_ready=1, c_valid=0, c=3'b111, err=0, busy=0.
- cnt_st1, cnt_st2, cnt_st3 = 0.
REQ-017 Reset mid-burst or mid-gap SHALL abort the operation with no further transfers; the aborted request SHALL not resume.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- GAP=1, st1 with req_len=3, c_ready=1 -> c=000,001,000,001 on 4 consecutive cycles; cnt_st1=4; 1 gap cycle; req_ready=1 again.
- st2 with req_len=1, c_ready low for 3 cycles after the first code -> c=100 held for 4 cycles, then a second 100; cnt_st2=2.
- req_sel=00 -> err high for 1 cycle, c_valid stays 0, all counters unchanged.
- GAP=0, st3 with req_len=0 immediately followed by st2 with req_len=0 -> c=001, one IDLE cycle with c=111, then c=100.
- 17 bursts of st3 with req_len=15 (272 codes) -> cnt_st3 saturates at 255.
- rst_n=0 during the third code of a 16-code st1 burst -> next cycle c_valid=0, c=111, cnt_st1=0, t=0, no further codes.
